lcd_char_sequencer: RTL and testbench
=====================================

# lcd_char_sequencer

Upstream feeder for the character-LCD Avalon slave. Buffers command/character bytes in a small FIFO, then for each byte polls the HD44780 busy flag and issues the write as Avalon-MM master transfers. Read/write strobes are held long enough to meet controller setup, E-pulse and hold timing, because the slave maps `read|write` directly onto `LCD_E` and `address` onto `RS`/`RW`.

## Interface
- `FIFO_DEPTH`, 16: entries in the input FIFO; power of two, at least 2.
- `SETUP_CYCLES`, 3: cycles that address and writedata are stable before the strobe (`RS`/`RW` to `E` setup).
- `E_CYCLES`, 12: cycles the strobe is held high (the E pulse); at least 1.
- `HOLD_CYCLES`, 2: cycles address and writedata are held after the strobe drops.
- `POLL_MAX`, 1023: busy polls allowed per byte before a timeout.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an upstream byte is offered.
- `in_ready` out 1: FIFO not full.
- `in_data` in 9: bit 8 = RS (1 = character, 0 = command); bits 7:0 = byte.
- `lcd_address` out 2: to the slave `address`; bit 1 = RS, bit 0 = RW.
- `lcd_read` out 1: slave read strobe.
- `lcd_write` out 1: slave write strobe.
- `lcd_begintransfer` out 1: one-cycle pulse on the first strobe cycle.
- `lcd_writedata` out 8: byte to write.
- `lcd_readdata` in 8: slave readdata; bit 7 = busy flag.
- `busy` out 1: FIFO not empty or FSM not in IDLE.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `timeout` out 1: sticky; set when a poll limit is hit.
- `timeout_clr` in 1: clears `timeout`.

## Operation
- **FIFO**
  - Push when `in_valid & in_ready`.
  - Pop on the last `WR_HOLD` cycle.
  - Push and pop in the same cycle while full: the pop frees space that cycle, but `in_ready` is based on the registered full flag, so no push is accepted while full.
  - Push and pop in the same cycle otherwise: level unchanged.
- **FSM states:** IDLE, RD_SU, RD_E, RD_HOLD, WR_SU, WR_E, WR_HOLD. One down-counter is loaded on each state entry.
- **IDLE:** all strobes 0, `lcd_address`=2'b01. Go to RD_SU when the FIFO is not empty.
- **Read phases**
  - RD_SU: address 2'b01 (status read, RW=1). Lasts SETUP_CYCLES, then RD_E.
  - RD_E: `lcd_read`=1 for E_CYCLES. `lcd_readdata[7]` is sampled on the last RD_E cycle. Then RD_HOLD.
  - RD_HOLD: lasts HOLD_CYCLES.
    - Sampled busy=1 and poll count < POLL_MAX: increment poll count, go to RD_SU.
    - Otherwise: go to WR_SU. If the limit was the cause, set `timeout`.
- **Write phases**
  - WR_SU: address {head[8],1'b0}, `lcd_writedata`=head[7:0]. Lasts SETUP_CYCLES.
  - WR_E: `lcd_write`=1 for E_CYCLES.
  - WR_HOLD: lasts HOLD_CYCLES, then pop, clear poll count, go to IDLE.
- **Held values:** `lcd_writedata` and `lcd_address` are constant from WR_SU entry through WR_HOLD exit.
- **`lcd_begintransfer`:** 1 only on the first cycle of RD_E and of WR_E.
- **Outputs:** all registered. `lcd_read` and `lcd_write` are never both 1.
- **`timeout` priority:** `timeout_clr` and a new timeout event in the same cycle → `timeout`=1 (set wins).
- **Reset, including mid-transfer:**
  - State IDLE; FIFO emptied (contents discarded); counters 0.
  - Outputs: `lcd_read`=`lcd_write`=`lcd_begintransfer`=0, `lcd_address`=2'b01, `lcd_writedata`=0, `timeout`=0, `busy`=0, `fifo_level`=0.
  - `in_ready`=1 once the FIFO is empty.
  - A strobe aborted by reset drops in the same instant (asynchronous).

## Timing
- **First strobe:** byte accepted at edge k into an empty FIFO with FSM idle → RD_SU entered at edge k+1 → `lcd_read` high from edge k+1+SETUP_CYCLES.
- **Per poll:** SETUP_CYCLES+E_CYCLES+HOLD_CYCLES cycles (17 with defaults).
- **Per write:** the same, 17 cycles.
- **Byte with no busy retries:** 34 cycles from RD_SU entry to IDLE.
- **Back-to-back bytes:** one IDLE cycle between WR_HOLD exit and the next RD_SU.
- **`in_ready` after a pop:** rises the cycle after the pop edge.
- **`timeout`:** set at the RD_HOLD→WR_SU edge.
- **`timeout_clr`:** takes effect at the next edge.

## Test plan
- Reset, then push 9'h141 ('A', data) with `lcd_readdata`=8'h00 → read strobe for 12 cycles at address 1; write strobe for 12 cycles at address 2 with writedata 8'h41; `begintransfer` pulses twice; `busy` returns to 0 after 35 cycles.
- Push command 9'h001 with busy=1 for the first 3 polls → 4 read strobes, then one write at address 0 with data 8'h01; `timeout`=0.
- Push 17 bytes back-to-back with busy=0 → `in_ready` low after 16 accepted; all 17 are written in order; `fifo_level` peaks at 16.
- Busy held at 1 → POLL_MAX+1 polls, then the write proceeds and `timeout`=1. Assert `timeout_clr` → `timeout` clears on the next edge.
- Assert `reset` during WR_E → strobes drop immediately; FIFO empties; after release, no write completes for the aborted byte.
- Throughout all tests, check that `lcd_address` and `lcd_writedata` never change while `lcd_write`=1 or within HOLD_CYCLES after it falls.

Source files
------------

// File: rtl/lcd_char_sequencer.sv
// Feeds command/character bytes from a small FIFO to the character-LCD Avalon slave.
// For each byte it polls the HD44780 busy flag, then writes the byte with stretched strobes.
module lcd_char_sequencer #(
   parameter int FIFO_DEPTH   = 16,
   parameter int SETUP_CYCLES = 3,
   parameter int E_CYCLES     = 12,
   parameter int HOLD_CYCLES  = 2,
   parameter int POLL_MAX     = 1023
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [8:0]                    in_data,
   output logic [1:0]                    lcd_address,
   output logic                          lcd_read,
   output logic                          lcd_write,
   output logic                          lcd_begintransfer,
   output logic [7:0]                    lcd_writedata,
   input  logic [7:0]                    lcd_readdata,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          timeout,
   input  logic                          timeout_clr
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LW     = AW + 1;
   localparam int MAXDUR = (SETUP_CYCLES > E_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((E_CYCLES > HOLD_CYCLES) ? E_CYCLES : HOLD_CYCLES);
   localparam int CW     = $clog2(MAXDUR + 1);
   localparam int PW     = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;

   // A phase length of zero is treated as one cycle so the counter never underflows.
   localparam logic [CW-1:0] SU_LOAD   = CW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
   localparam logic [CW-1:0] E_LOAD    = CW'((E_CYCLES > 0) ? E_CYCLES - 1 : 0);
   localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [PW-1:0] POLL_LIM  = PW'(POLL_MAX);
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_SU   = 3'd1;
   localparam logic [2:0] RD_E    = 3'd2;
   localparam logic [2:0] RD_HOLD = 3'd3;
   localparam logic [2:0] WR_SU   = 3'd4;
   localparam logic [2:0] WR_E    = 3'd5;
   localparam logic [2:0] WR_HOLD = 3'd6;

   logic [8:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [LW-1:0] count_q, count_d;
   logic          inReady_q;
   logic [8:0]    head;
   logic          push, pop;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pollCnt_q, pollCnt_d;
   logic          busyFlag_q;
   logic          timeoutSet;
   logic          timeout_q;
   logic          busy_q;
   logic          read_q, write_q, beginXfer_q;
   logic [1:0]    address_q;
   logic [7:0]    writedata_q;
   logic          writeSel;
   logic          unusedReaddata;

   assign unusedReaddata = ^lcd_readdata[6:0];
   assign push           = in_valid && inReady_q;
   assign head           = mem_q[rdPtr_q];
   assign writeSel       = state_d inside {WR_SU, WR_E, WR_HOLD};

   assign in_ready          = inReady_q;
   assign fifo_level        = count_q;
   assign busy              = busy_q;
   assign timeout           = timeout_q;
   assign lcd_read          = read_q;
   assign lcd_write         = write_q;
   assign lcd_begintransfer = beginXfer_q;
   assign lcd_address       = address_q;
   assign lcd_writedata     = writedata_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= in_data;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Every state reloads the shared down-counter on entry and leaves when it reaches zero.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pollCnt_d  = pollCnt_q;
      timeoutSet = 1'b0;
      pop        = 1'b0;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = RD_SU;
               cnt_d   = SU_LOAD;
            end
         end
         RD_SU: begin
            if (cnt_q == '0) begin
               state_d = RD_E;
               cnt_d   = E_LOAD;
            end
         end
         RD_E: begin
            if (cnt_q == '0) begin
               state_d = RD_HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         RD_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d = SU_LOAD;
               if (busyFlag_q && (pollCnt_q < POLL_LIM)) begin
                  pollCnt_d = pollCnt_q + 1'b1;
                  state_d   = RD_SU;
               end else begin
                  state_d    = WR_SU;
                  timeoutSet = busyFlag_q;
               end
            end
         end
         WR_SU: begin
            if (cnt_q == '0) begin
               state_d = WR_E;
               cnt_d   = E_LOAD;
            end
         end
         WR_E: begin
            if (cnt_q == '0) begin
               state_d = WR_HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         WR_HOLD: begin
            if (cnt_q == '0) begin
               pop       = 1'b1;
               pollCnt_d = '0;
               state_d   = IDLE;
               cnt_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         inReady_q   <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         pollCnt_q   <= '0;
         busyFlag_q  <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         beginXfer_q <= 1'b0;
         address_q   <= 2'b01;
         writedata_q <= 8'h00;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q   <= count_d;
         inReady_q <= (count_d != FULL_LVL);
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pollCnt_q <= pollCnt_d;
         if ((state_q == RD_E) && (cnt_q == '0)) begin
            busyFlag_q <= lcd_readdata[7];
         end
         if (timeoutSet) begin
            timeout_q <= 1'b1;
         end else if (timeout_clr) begin
            timeout_q <= 1'b0;
         end
         busy_q      <= (count_d != '0) || (state_d != IDLE);
         read_q      <= (state_d == RD_E);
         write_q     <= (state_d == WR_E);
         beginXfer_q <= ((state_d == RD_E) && (state_q != RD_E)) ||
                        ((state_d == WR_E) && (state_q != WR_E));
         address_q   <= writeSel ? {head[8], 1'b0} : 2'b01;
         if ((state_d == WR_SU) && (state_q != WR_SU)) begin
            writedata_q <= head[7:0];
         end
      end
   end

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// Directed bench for lcd_char_sequencer: strobe shapes, busy polling, FIFO fill, timeout and reset abort.
module tb_lcd_char_sequencer;

   localparam int HOLD = 2;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      int         len;
   } wrRec_t;

   logic       clk;
   logic       reset;
   logic       inValid;
   logic       inReady;
   logic [8:0] inData;
   logic [1:0] lcdAddress;
   logic       lcdRead;
   logic       lcdWrite;
   logic       lcdBegin;
   logic [7:0] lcdWritedata;
   logic [7:0] lcdReaddata;
   logic       busy;
   logic [4:0] fifoLevel;
   logic       timeout;
   logic       timeoutClr;

   int testsRun  = 0;
   int failCount = 0;
   int cycleCnt  = 0;

   int     rdRuns[$];
   wrRec_t wrQ[$];
   wrRec_t curWr;
   int     rdRun = 0;
   int     wrRun = 0;
   int     btCount = 0;
   int     bothHigh = 0;
   int     rdAddrBad = 0;
   int     busyPollsLeft = 0;

   logic [1:0] holdAddr;
   logic [7:0] holdData;
   int         holdLeft = 0;
   logic       inWindow = 1'b0;

   lcd_char_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (inValid),
      .in_ready          (inReady),
      .in_data           (inData),
      .lcd_address       (lcdAddress),
      .lcd_read          (lcdRead),
      .lcd_write         (lcdWrite),
      .lcd_begintransfer (lcdBegin),
      .lcd_writedata     (lcdWritedata),
      .lcd_readdata      (lcdReaddata),
      .busy              (busy),
      .fifo_level        (fifoLevel),
      .timeout           (timeout),
      .timeout_clr       (timeoutClr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [8:0] data);
      @(negedge clk);
      inValid = 1'b1;
      inData  = data;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
   endtask

   // Records completed strobe runs and plays the LCD busy flag back to the read port.
   always @(negedge clk) begin
      if (reset) begin
         rdRun = 0;
         wrRun = 0;
      end else begin
         if (lcdRead && lcdWrite) bothHigh++;
         if (lcdBegin) btCount++;
         if (lcdRead) begin
            if (lcdAddress != 2'b01) rdAddrBad++;
            rdRun++;
         end else if (rdRun > 0) begin
            rdRuns.push_back(rdRun);
            rdRun = 0;
            if (busyPollsLeft > 0) busyPollsLeft--;
         end
         if (lcdWrite) begin
            if (wrRun == 0) begin
               curWr.addr = lcdAddress;
               curWr.data = lcdWritedata;
            end
            wrRun++;
         end else if (wrRun > 0) begin
            curWr.len = wrRun;
            wrQ.push_back(curWr);
            wrRun = 0;
         end
      end
      lcdReaddata = (busyPollsLeft > 0) ? 8'h80 : 8'h00;
   end

   // Address and data must stay put for the whole write pulse and the hold cycles after it.
   always @(negedge clk) begin
      if (reset) begin
         inWindow = 1'b0;
         holdLeft = 0;
      end else if (lcdWrite) begin
         if (!inWindow) begin
            holdAddr = lcdAddress;
            holdData = lcdWritedata;
            inWindow = 1'b1;
         end else begin
            checkOutput("holdAddr", 32'(lcdAddress), 32'(holdAddr));
            checkOutput("holdData", 32'(lcdWritedata), 32'(holdData));
         end
         holdLeft = HOLD;
      end else if (inWindow && holdLeft > 0) begin
         checkOutput("holdAddr", 32'(lcdAddress), 32'(holdAddr));
         checkOutput("holdData", 32'(lcdWritedata), 32'(holdData));
         holdLeft--;
      end else begin
         inWindow = 1'b0;
      end
   end

   initial begin
      logic [8:0] bytes [17];
      int j;
      int firstRd;
      int firstWr;
      int idx;
      int peak;
      int startCyc;
      int lastCyc;
      int endCyc;
      logic acc;
      logic sawStall;

      reset      = 1'b1;
      inValid    = 1'b0;
      inData     = 9'h000;
      timeoutClr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rstRead", 32'(lcdRead), 32'h0);
      checkOutput("rstWrite", 32'(lcdWrite), 32'h0);
      checkOutput("rstBegin", 32'(lcdBegin), 32'h0);
      checkOutput("rstAddr", 32'(lcdAddress), 32'h1);
      checkOutput("rstData", 32'(lcdWritedata), 32'h0);
      checkOutput("rstTimeout", 32'(timeout), 32'h0);
      checkOutput("rstBusy", 32'(busy), 32'h0);
      checkOutput("rstLevel", 32'(fifoLevel), 32'h0);
      checkOutput("rstReady", 32'(inReady), 32'h1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single character byte, controller idle
      $display("[TB] single character write");
      rdRuns.delete(); wrQ.delete(); btCount = 0; busyPollsLeft = 0;
      applyStimulus(9'h141);
      checkOutput("t1Level", 32'(fifoLevel), 32'h1);
      checkOutput("t1Busy", 32'(busy), 32'h1);
      j = 0; firstRd = -1; firstWr = -1;
      while (busy && j < 200) begin
         @(negedge clk);
         j++;
         if (lcdRead && firstRd < 0) firstRd = j;
         if (lcdWrite && firstWr < 0) firstWr = j;
      end
      checkOutput("t1BusyCycles", 32'(j), 32'd35);
      checkOutput("t1FirstRead", 32'(firstRd), 32'd4);
      checkOutput("t1FirstWrite", 32'(firstWr), 32'd21);
      checkOutput("t1ReadCount", 32'(rdRuns.size()), 32'd1);
      if (rdRuns.size() > 0) checkOutput("t1ReadLen", 32'(rdRuns[0]), 32'd12);
      checkOutput("t1WriteCount", 32'(wrQ.size()), 32'd1);
      if (wrQ.size() > 0) begin
         checkOutput("t1WriteLen", 32'(wrQ[0].len), 32'd12);
         checkOutput("t1WriteAddr", 32'(wrQ[0].addr), 32'h2);
         checkOutput("t1WriteData", 32'(wrQ[0].data), 32'h41);
      end
      checkOutput("t1Begin", 32'(btCount), 32'd2);
      checkOutput("t1IdleAddr", 32'(lcdAddress), 32'h1);

      // Command byte with three busy polls before the controller is ready
      $display("[TB] command with busy retries");
      rdRuns.delete(); wrQ.delete(); btCount = 0; busyPollsLeft = 3;
      @(negedge clk);
      applyStimulus(9'h001);
      j = 0;
      while (busy && j < 300) begin
         @(negedge clk);
         j++;
      end
      checkOutput("t2BusyCycles", 32'(j), 32'd86);
      checkOutput("t2ReadCount", 32'(rdRuns.size()), 32'd4);
      for (int i = 0; i < rdRuns.size(); i++) checkOutput("t2ReadLen", 32'(rdRuns[i]), 32'd12);
      checkOutput("t2WriteCount", 32'(wrQ.size()), 32'd1);
      if (wrQ.size() > 0) begin
         checkOutput("t2WriteAddr", 32'(wrQ[0].addr), 32'h0);
         checkOutput("t2WriteData", 32'(wrQ[0].data), 32'h01);
      end
      checkOutput("t2Begin", 32'(btCount), 32'd5);
      checkOutput("t2Timeout", 32'(timeout), 32'h0);

      // Seventeen bytes offered back to back
      $display("[TB] FIFO fill");
      rdRuns.delete(); wrQ.delete(); busyPollsLeft = 0;
      for (int i = 0; i < 17; i++) bytes[i] = {i[0], 8'(8'h30 + i)};
      idx = 0; peak = 0; startCyc = 0; sawStall = 1'b0;
      for (int c = 0; c < 400 && idx < 17; c++) begin
         @(negedge clk);
         if (idx == 1 && startCyc == 0) startCyc = cycleCnt;
         if (32'(fifoLevel) > peak) peak = 32'(fifoLevel);
         if (idx == 16 && !sawStall) begin
            checkOutput("t3ReadyWhenFull", 32'(inReady), 32'h0);
            sawStall = 1'b1;
         end
         inValid = 1'b1;
         inData  = bytes[idx];
         acc     = inReady;
         @(posedge clk);
         if (acc) idx++;
      end
      @(negedge clk);
      inValid = 1'b0;
      lastCyc = cycleCnt;
      checkOutput("t3Accepted", 32'(idx), 32'd17);
      checkOutput("t3LastAccept", 32'(lastCyc - startCyc), 32'd36);
      j = 0;
      while (busy && j < 2000) begin
         @(negedge clk);
         j++;
      end
      endCyc = cycleCnt;
      checkOutput("t3Drained", 32'(busy), 32'h0);
      checkOutput("t3TotalCycles", 32'(endCyc - startCyc), 32'd595);
      checkOutput("t3Peak", 32'(peak), 32'd16);
      checkOutput("t3WriteCount", 32'(wrQ.size()), 32'd17);
      for (int i = 0; i < 17 && i < wrQ.size(); i++) begin
         checkOutput("t3WriteData", 32'(wrQ[i].data), 32'(bytes[i][7:0]));
         checkOutput("t3WriteAddr", 32'(wrQ[i].addr), 32'({bytes[i][8], 1'b0}));
      end

      // Controller never ready: poll limit, sticky timeout, then clear
      $display("[TB] poll timeout");
      rdRuns.delete(); wrQ.delete(); busyPollsLeft = 100000;
      @(negedge clk);
      applyStimulus(9'h1A5);
      for (int c = 0; c < 20000 && !timeout; c++) @(negedge clk);
      checkOutput("t4TimeoutSet", 32'(timeout), 32'h1);
      checkOutput("t4PollCount", 32'(rdRuns.size()), 32'd1024);
      busyPollsLeft = 0;
      j = 0;
      while (busy && j < 100) begin
         @(negedge clk);
         j++;
      end
      checkOutput("t4WriteCount", 32'(wrQ.size()), 32'd1);
      if (wrQ.size() > 0) begin
         checkOutput("t4WriteData", 32'(wrQ[0].data), 32'hA5);
         checkOutput("t4WriteAddr", 32'(wrQ[0].addr), 32'h2);
      end
      checkOutput("t4Sticky", 32'(timeout), 32'h1);
      timeoutClr = 1'b1;
      @(negedge clk);
      timeoutClr = 1'b0;
      checkOutput("t4Cleared", 32'(timeout), 32'h0);

      // Clear held high while a new timeout fires: the set must win for that edge
      $display("[TB] timeout set versus clear");
      rdRuns.delete(); wrQ.delete(); busyPollsLeft = 100000;
      timeoutClr = 1'b1;
      applyStimulus(9'h0AA);
      for (int c = 0; c < 20000 && !timeout; c++) @(negedge clk);
      checkOutput("t4bSetWins", 32'(timeout), 32'h1);
      checkOutput("t4bPollCount", 32'(rdRuns.size()), 32'd1024);
      @(negedge clk);
      checkOutput("t4bClearNext", 32'(timeout), 32'h0);
      timeoutClr = 1'b0;
      busyPollsLeft = 0;
      j = 0;
      while (busy && j < 100) begin
         @(negedge clk);
         j++;
      end
      checkOutput("t4bDone", 32'(busy), 32'h0);

      // Reset in the middle of a write pulse
      $display("[TB] reset during write");
      rdRuns.delete(); wrQ.delete(); busyPollsLeft = 0;
      applyStimulus(9'h155);
      j = 0;
      while (!lcdWrite && j < 100) begin
         @(negedge clk);
         j++;
      end
      checkOutput("t5WriteSeen", 32'(lcdWrite), 32'h1);
      applyStimulus(9'h166);
      checkOutput("t5LevelBefore", 32'(fifoLevel), 32'h2);
      checkOutput("t5StillWriting", 32'(lcdWrite), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("t5AbortWrite", 32'(lcdWrite), 32'h0);
      checkOutput("t5AbortRead", 32'(lcdRead), 32'h0);
      checkOutput("t5AbortBegin", 32'(lcdBegin), 32'h0);
      checkOutput("t5AbortAddr", 32'(lcdAddress), 32'h1);
      checkOutput("t5AbortData", 32'(lcdWritedata), 32'h0);
      checkOutput("t5AbortLevel", 32'(fifoLevel), 32'h0);
      checkOutput("t5AbortBusy", 32'(busy), 32'h0);
      checkOutput("t5AbortReady", 32'(inReady), 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("t5NoWrite", 32'(wrQ.size()), 32'd0);
      checkOutput("t5IdleBusy", 32'(busy), 32'h0);
      checkOutput("t5IdleLevel", 32'(fifoLevel), 32'h0);

      checkOutput("readWriteExclusive", 32'(bothHigh), 32'd0);
      checkOutput("readAddress", 32'(rdAddrBad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
